// File: rtl/otter_lsu_pkg.sv
// rtl/otter_lsu_pkg.sv - shared states and funct3/size encodings for the OTTER load/store unit
package otter_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_EN  = 3'd1,
    LD_CAP = 3'd2,
    ST     = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/otter_lsu_chk.sv
// rtl/otter_lsu_chk.sv - combinational funct3 legality and alignment check for one request
module otter_lsu_chk
  import otter_lsu_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic [2:0] funct3,
  input  logic       we,
  input  logic [1:0] addr,
  output logic       err
);

  logic bad_code;
  logic misaligned;

  // size 3 is never legal; stores have no unsigned variant
  always_comb begin
    bad_code = (funct3[1:0] == 2'b11) || (we && funct3[2]);
  end

  always_comb begin
    misaligned = 1'b0;
    if (CHECK_ALIGN) begin
      if (funct3[1:0] == SZ_HALF)
        misaligned = addr[0];
      else if (funct3[1:0] == SZ_WORD)
        misaligned = (addr != 2'b00);
    end
  end

  assign err = bad_code || misaligned;

endmodule

// File: rtl/otter_lsu.sv
// rtl/otter_lsu.sv - OTTER data-port initiator: one sized load/store at a time with fixed latency
module otter_lsu
  import otter_lsu_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE   = 32'h00010000,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LSU_REQ,
  input  logic        LSU_WE,
  input  logic [31:0] LSU_ADDR,
  input  logic [31:0] LSU_WDATA,
  input  logic [2:0]  LSU_FUNCT3,
  output logic        LSU_BUSY,
  output logic        LSU_DONE,
  output logic        LSU_ERR,
  output logic        LSU_IO,
  output logic [31:0] LSU_RDATA,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  lsu_state_t state, state_nxt;
  logic       req_err;
  logic       err_q;
  logic       accept;

  otter_lsu_chk #(
    .CHECK_ALIGN(CHECK_ALIGN)
  ) u_chk (
    .funct3(LSU_FUNCT3),
    .we    (LSU_WE),
    .addr  (LSU_ADDR[1:0]),
    .err   (req_err)
  );

  assign accept = (state == IDLE) && LSU_REQ;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (LSU_REQ) begin
          if (req_err)     state_nxt = RESP;
          else if (LSU_WE) state_nxt = ST;
          else             state_nxt = LD_EN;
        end
      end
      LD_EN:   state_nxt = LD_CAP;
      LD_CAP:  state_nxt = RESP;
      ST:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Strobes are registered from next-state so they line up exactly with LD_EN/ST.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MEM_RDEN2 <= 1'b0;
      MEM_WE2   <= 1'b0;
    end else begin
      MEM_RDEN2 <= (state_nxt == LD_EN);
      MEM_WE2   <= (state_nxt == ST);
    end
  end

  // Request latch: memory sizes read data from these, so they stay put until IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MEM_ADDR2 <= '0;
      MEM_DIN2  <= '0;
      MEM_SIZE  <= '0;
      MEM_SIGN  <= 1'b0;
      LSU_IO    <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      MEM_ADDR2 <= LSU_ADDR;
      MEM_DIN2  <= LSU_WDATA;
      MEM_SIZE  <= LSU_FUNCT3[1:0];
      MEM_SIGN  <= LSU_FUNCT3[2];
      LSU_IO    <= (LSU_ADDR >= MMIO_BASE);
      err_q     <= req_err;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)               LSU_RDATA <= '0;
    else if (state == LD_CAP) LSU_RDATA <= MEM_DOUT2;
  end

  assign LSU_BUSY = (state != IDLE);
  assign LSU_DONE = (state == RESP);
  assign LSU_ERR  = (state == RESP) && err_q;

endmodule

// File: tb/tb_otter_lsu.sv
// tb/tb_otter_lsu.sv - vector table plus scoreboard bench for otter_lsu against a BRAM/IO model
module tb_otter_lsu;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        LSU_REQ = 1'b0;
  logic        LSU_WE = 1'b0;
  logic [31:0] LSU_ADDR = '0;
  logic [31:0] LSU_WDATA = '0;
  logic [2:0]  LSU_FUNCT3 = '0;
  logic        LSU_BUSY, LSU_DONE, LSU_ERR, LSU_IO;
  logic [31:0] LSU_RDATA;
  logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
  logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
  logic [1:0]  MEM_SIZE;

  otter_lsu dut (
    .CLK(CLK), .RST_N(RST_N), .LSU_REQ(LSU_REQ), .LSU_WE(LSU_WE),
    .LSU_ADDR(LSU_ADDR), .LSU_WDATA(LSU_WDATA), .LSU_FUNCT3(LSU_FUNCT3),
    .LSU_BUSY(LSU_BUSY), .LSU_DONE(LSU_DONE), .LSU_ERR(LSU_ERR), .LSU_IO(LSU_IO),
    .LSU_RDATA(LSU_RDATA), .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE),
    .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
  );

  always #5 CLK = ~CLK;

  // memory model: registered word on RDEN2, combinational sizing from latched size/sign/addr
  localparam logic [31:0] MMIO = 32'h00010000;
  logic [31:0] mem [0:1023];
  logic [31:0] io_in = 32'hCAFEF00D;
  logic [31:0] rd_word = '0;
  logic [31:0] sh;

  always @(posedge CLK) begin
    if (MEM_RDEN2) rd_word <= (MEM_ADDR2 >= MMIO) ? io_in : mem[MEM_ADDR2[11:2]];
    if (MEM_WE2 && MEM_ADDR2 < MMIO) begin
      case (MEM_SIZE)
        2'd0:    mem[MEM_ADDR2[11:2]][{MEM_ADDR2[1:0], 3'b000} +: 8] <= MEM_DIN2[7:0];
        2'd1:    mem[MEM_ADDR2[11:2]][{MEM_ADDR2[1], 4'b0000} +: 16] <= MEM_DIN2[15:0];
        default: mem[MEM_ADDR2[11:2]] <= MEM_DIN2;
      endcase
    end
  end

  always_comb begin
    sh = rd_word >> {MEM_ADDR2[1:0], 3'b000};
    case (MEM_SIZE)
      2'd0:    MEM_DOUT2 = MEM_SIGN ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1:    MEM_DOUT2 = MEM_SIGN ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: MEM_DOUT2 = rd_word;
    endcase
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic        io;
    int          lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        io;
    int          lat;
    int          rd_cnt;
    int          wr_cnt;
  } exp_t;

  vec_t vecs[15];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                              input logic io, input int lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.io = io; v.lat = lat;
    return v;
  endfunction

  // pop one expectation and compare against the completion just observed
  task automatic score(input string tag, input int lat, input int rd_cnt, input int wr_cnt);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected_done actual=1 expected=0", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_err"}, {31'h0, LSU_ERR}, {31'h0, e.err});
    chk({tag, "_rdata"}, LSU_RDATA, e.rdata);
    chk({tag, "_io"}, {31'h0, LSU_IO}, {31'h0, e.io});
    chk({tag, "_lat"}, lat, e.lat);
    chk({tag, "_rden_cycles"}, rd_cnt, e.rd_cnt);
    chk({tag, "_we_cycles"}, wr_cnt, e.wr_cnt);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    exp_t e;
    int   lat = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    e.err = v.err; e.rdata = v.rdata; e.io = v.io; e.lat = v.lat;
    e.rd_cnt = (!v.err && !v.we) ? 1 : 0;
    e.wr_cnt = (!v.err && v.we) ? 1 : 0;
    @(negedge CLK);
    LSU_REQ = 1'b1; LSU_WE = v.we; LSU_FUNCT3 = v.f3; LSU_ADDR = v.addr; LSU_WDATA = v.wdata;
    exp_q.push_back(e);
    @(posedge CLK);
    #1 LSU_REQ = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      rd_cnt += int'(MEM_RDEN2);
      wr_cnt += int'(MEM_WE2);
      if (LSU_DONE) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done expected=done", tag);
      void'(exp_q.pop_front());
    end else begin
      score(tag, lat, rd_cnt, wr_cnt);
    end
  endtask

  initial begin
    int dones;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h040] = 32'h8899AABB;
    mem[10'h080] = 32'h55667788;
    mem[10'h0C0] = 32'h01020304;

    vecs[0]  = mk(1'b0, 3'b010, 32'h00000100, 32'h0,    1'b0, 32'h8899AABB, 1'b0, 3);
    vecs[1]  = mk(1'b0, 3'b000, 32'h00000103, 32'h0,    1'b0, 32'hFFFFFF88, 1'b0, 3);
    vecs[2]  = mk(1'b0, 3'b100, 32'h00000103, 32'h0,    1'b0, 32'h00000088, 1'b0, 3);
    vecs[3]  = mk(1'b0, 3'b101, 32'h00000102, 32'h0,    1'b0, 32'h00008899, 1'b0, 3);
    vecs[4]  = mk(1'b0, 3'b001, 32'h00000102, 32'h0,    1'b0, 32'hFFFF8899, 1'b0, 3);
    vecs[5]  = mk(1'b1, 3'b001, 32'h00000202, 32'h1234, 1'b0, 32'hFFFF8899, 1'b0, 2);
    vecs[6]  = mk(1'b0, 3'b010, 32'h00000200, 32'h0,    1'b0, 32'h12347788, 1'b0, 3);
    vecs[7]  = mk(1'b0, 3'b010, 32'h00000101, 32'h0,    1'b1, 32'h12347788, 1'b0, 1);
    vecs[8]  = mk(1'b1, 3'b001, 32'h00000203, 32'h5555, 1'b1, 32'h12347788, 1'b0, 1);
    vecs[9]  = mk(1'b0, 3'b011, 32'h00000100, 32'h0,    1'b1, 32'h12347788, 1'b0, 1);
    vecs[10] = mk(1'b1, 3'b100, 32'h00000200, 32'hFF,   1'b1, 32'h12347788, 1'b0, 1);
    vecs[11] = mk(1'b1, 3'b000, 32'h00000201, 32'hAB,   1'b0, 32'h12347788, 1'b0, 2);
    vecs[12] = mk(1'b0, 3'b010, 32'h00000200, 32'h0,    1'b0, 32'h1234AB88, 1'b0, 3);
    vecs[13] = mk(1'b0, 3'b010, 32'h11000000, 32'h0,    1'b0, 32'hCAFEF00D, 1'b1, 3);
    vecs[14] = mk(1'b0, 3'b000, 32'h00000102, 32'h0,    1'b0, 32'hFFFFFF99, 1'b0, 3);

    repeat (3) @(negedge CLK);
    chk("reset_outputs",
        {22'h0, LSU_BUSY, LSU_DONE, LSU_ERR, LSU_IO, MEM_RDEN2, MEM_WE2, MEM_SIZE, MEM_SIGN, 1'b0},
        32'h0);
    chk("reset_rdata", LSU_RDATA, 32'h0);
    chk("reset_addr_din", MEM_ADDR2 | MEM_DIN2, 32'h0);
    RST_N = 1'b1;

    for (int i = 0; i < 15; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // a second REQ pulse while busy must be ignored
    begin
      exp_t e;
      e.err = 1'b0; e.rdata = 32'h8899AABB; e.io = 1'b0; e.lat = 3; e.rd_cnt = 1; e.wr_cnt = 0;
      @(negedge CLK);
      LSU_REQ = 1'b1; LSU_WE = 1'b0; LSU_FUNCT3 = 3'b010; LSU_ADDR = 32'h100;
      exp_q.push_back(e);
      @(posedge CLK);
      #1 LSU_REQ = 1'b0;
      @(negedge CLK);
      LSU_REQ = 1'b1;
      @(negedge CLK);
      LSU_REQ = 1'b0;
      dones = 0;
      for (int c = 3; c <= 10; c++) begin
        @(negedge CLK);
        if (LSU_DONE) begin
          dones++;
          if (dones == 1) score("busy_ignore", c, 1, 0);
        end
      end
      chk("busy_done_count", dones, 1);
    end

    // reset asserted during the store cycle must cancel the write entirely
    @(negedge CLK);
    LSU_REQ = 1'b1; LSU_WE = 1'b1; LSU_FUNCT3 = 3'b010; LSU_ADDR = 32'h300; LSU_WDATA = 32'hDEADBEEF;
    @(posedge CLK);
    #1 LSU_REQ = 1'b0;
    chk("st_we_high", {31'h0, MEM_WE2}, 32'h1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_we_drop", {31'h0, MEM_WE2}, 32'h0);
    chk("rst_outputs",
        {24'h0, LSU_BUSY, LSU_DONE, LSU_ERR, LSU_IO, MEM_RDEN2, MEM_SIZE, MEM_SIGN}, 32'h0);
    chk("rst_rdata", LSU_RDATA, 32'h0);
    chk("rst_addr_din", MEM_ADDR2 | MEM_DIN2, 32'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    chk("rst_mem_word", mem[10'h0C0], 32'h01020304);
    run_vec("post_reset_lw", mk(1'b0, 3'b010, 32'h00000300, 32'h0, 1'b0, 32'h01020304, 1'b0, 3));

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
